// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch
// flushes, multi-cycle data-memory waits and a sticky trap for a hung memory access.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int REG_AW      = 5
) (
    input  logic              clkIn,
    input  logic              resetn,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ack,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              memwb_bubble,
    output logic              mem_timeout_err,
    output logic [15:0]       stall_cnt,
    output logic [1:0]        state_dbg
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    // Last MEM_WAIT cycle count before the access is declared hung.
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t         state, state_nx;
    logic [WCW-1:0] wait_cnt, wait_nx;
    logic           load_use;

    // Outputs of the no-memory-stall rules (branch, load-use, normal).
    logic [7:0]     run_out;
    logic [7:0]     sel_out;

    localparam logic [7:0] OUT_NORMAL = 8'b11111_000;
    localparam logic [7:0] OUT_BRANCH = 8'b11111_110;
    localparam logic [7:0] OUT_LDUSE  = 8'b00111_010;
    localparam logic [7:0] OUT_MSTALL = 8'b00001_001;

    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        run_out = OUT_NORMAL;
        if (ex_branch_taken)
            run_out = OUT_BRANCH;
        else if (load_use)
            run_out = OUT_LDUSE;
    end

    always_comb begin
        sel_out  = 8'b0;
        state_nx = state;
        wait_nx  = wait_cnt;
        case (state)
            RUN: begin
                if (mem_req && !mem_ack) begin
                    sel_out  = OUT_MSTALL;
                    state_nx = (MEM_TIMEOUT == 1) ? ERR : MEM_WAIT;
                    wait_nx  = WCW'(1);
                end else begin
                    sel_out = run_out;
                end
            end
            MEM_WAIT: begin
                if (!mem_ack) begin
                    sel_out = OUT_MSTALL;
                    wait_nx = wait_cnt + WCW'(1);
                    if (wait_cnt >= WAIT_LAST)
                        state_nx = ERR;
                end else begin
                    sel_out  = run_out;
                    state_nx = RUN;
                    wait_nx  = '0;
                end
            end
            default: begin
                sel_out = 8'b0;
            end
        endcase
    end

    // Reset forces every enable low immediately, independent of the clock.
    always_comb begin
        if (!resetn) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, memwb_bubble} = 8'b0;
            mem_timeout_err = 1'b0;
        end else begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, memwb_bubble} = sel_out;
            mem_timeout_err = (state == ERR);
        end
    end

    always_ff @(posedge clkIn or negedge resetn) begin
        if (!resetn) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= 16'd0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            if ((state != ERR) && !pc_en && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: hazard priorities, memory waits,
// timeout trap and asynchronous reset, with hand-computed expectations.
module tb_pipeline_hazard_ctrl;

    localparam int AW = 5;

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_bubble, err}
    localparam logic [8:0] V_ZERO   = 9'b00000_000_0;
    localparam logic [8:0] V_NORMAL = 9'b11111_000_0;
    localparam logic [8:0] V_BRANCH = 9'b11111_110_0;
    localparam logic [8:0] V_LDUSE  = 9'b00111_010_0;
    localparam logic [8:0] V_MSTALL = 9'b00001_001_0;
    localparam logic [8:0] V_ERR    = 9'b00000_000_1;

    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_ERR = 2'd2;

    logic          clkIn = 1'b0;
    logic          resetn;
    logic [AW-1:0] id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
    logic          mem_req, mem_ack;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_flush, idex_flush, memwb_bubble, mem_timeout_err;
    logic [15:0]   stall_cnt;
    logic [1:0]    state_dbg;
    logic [8:0]    ctrl;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [15:0]   exp_stall;
    logic [9:0]    req_pat;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(15), .REG_AW(AW)) dut (
        .clkIn(clkIn), .resetn(resetn),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .memwb_bubble(memwb_bubble), .mem_timeout_err(mem_timeout_err),
        .stall_cnt(stall_cnt), .state_dbg(state_dbg)
    );

    assign ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                   ifid_flush, idex_flush, memwb_bubble, mem_timeout_err};

    always #5 clkIn = ~clkIn;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; Mealy outputs are sampled 3 ns later.
    task automatic next_cycle();
        @(posedge clkIn);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic reset_pulse(input string tag);
        resetn = 1'b0;
        #1;
        check({tag, "_rst_ctrl"}, 32'(ctrl), 32'(V_ZERO));
        check({tag, "_rst_stall"}, 32'(stall_cnt), 32'd0);
        check({tag, "_rst_state"}, 32'(state_dbg), 32'(S_RUN));
        next_cycle();
        resetn = 1'b1;
        exp_stall = 16'd0;
    endtask

    initial begin
        idle_inputs();
        exp_stall = 16'd0;
        resetn = 1'b0;
        #3;
        check("reset_ctrl", 32'(ctrl), 32'(V_ZERO));
        check("reset_stall", 32'(stall_cnt), 32'd0);
        check("reset_state", 32'(state_dbg), 32'(S_RUN));
        next_cycle();
        next_cycle();
        resetn = 1'b1;

        // 1: zero-wait accesses only, never a stall.
        req_pat = 10'b1011001101;
        for (int i = 0; i < 10; i++) begin
            mem_req = req_pat[i];
            mem_ack = req_pat[i];
            settle();
            check($sformatf("t1_ctrl_%0d", i), 32'(ctrl), 32'(V_NORMAL));
            next_cycle();
        end
        idle_inputs();
        check("t1_stall", 32'(stall_cnt), 32'd0);

        // 2: load-use through rs2, then normal once the load has moved on.
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        id_rs1 = 5'd3; id_use_rs1 = 1'b1;
        settle();
        check("t2_lduse_rs2", 32'(ctrl), 32'(V_LDUSE));
        next_cycle();
        exp_stall = exp_stall + 16'd1;
        check("t2_stall", 32'(stall_cnt), 32'(exp_stall));
        ex_mem_read = 1'b0;
        settle();
        check("t2_after", 32'(ctrl), 32'(V_NORMAL));
        next_cycle();

        // Load-use through rs1.
        ex_mem_read = 1'b1; ex_rd = 5'd3; id_use_rs2 = 1'b0;
        settle();
        check("t2_lduse_rs1", 32'(ctrl), 32'(V_LDUSE));
        next_cycle();
        exp_stall = exp_stall + 16'd1;
        check("t2_stall_rs1", 32'(stall_cnt), 32'(exp_stall));

        // 3: x0 destination, unused source, and branch-over-load-use.
        idle_inputs();
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1'b1;
        settle();
        check("t3_rd_zero", 32'(ctrl), 32'(V_NORMAL));
        next_cycle();
        ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b0;
        settle();
        check("t3_no_use", 32'(ctrl), 32'(V_NORMAL));
        next_cycle();
        id_use_rs2 = 1'b1; ex_branch_taken = 1'b1;
        settle();
        check("t3_branch_wins", 32'(ctrl), 32'(V_BRANCH));
        next_cycle();
        check("t3_stall", 32'(stall_cnt), 32'(exp_stall));
        idle_inputs();

        // 4: three-cycle memory wait.
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("t4_wait_%0d", i), 32'(ctrl), 32'(V_MSTALL));
            next_cycle();
            exp_stall = exp_stall + 16'd1;
        end
        mem_ack = 1'b1;
        settle();
        check("t4_ack", 32'(ctrl), 32'(V_NORMAL));
        next_cycle();
        idle_inputs();
        check("t4_state", 32'(state_dbg), 32'(S_RUN));
        check("t4_stall", 32'(stall_cnt), 32'(exp_stall));

        // 5: hung access traps after 15 stall cycles.
        reset_pulse("t5a");
        mem_req = 1'b1;
        for (int i = 0; i < 15; i++) begin
            settle();
            check($sformatf("t5_wait_%0d", i), 32'(ctrl), 32'(V_MSTALL));
            next_cycle();
        end
        check("t5_state", 32'(state_dbg), 32'(S_ERR));
        check("t5_ctrl", 32'(ctrl), 32'(V_ERR));
        check("t5_stall", 32'(stall_cnt), 32'd15);
        mem_ack = 1'b1; ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) next_cycle();
        check("t5_sticky", 32'(ctrl), 32'(V_ERR));
        check("t5_frozen", 32'(stall_cnt), 32'd15);
        idle_inputs();
        reset_pulse("t5b");
        settle();
        check("t5_recover", 32'(ctrl), 32'(V_NORMAL));
        next_cycle();

        // 6: branch held across a 2-cycle wait flushes only in the ack cycle.
        mem_req = 1'b1; ex_branch_taken = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            check($sformatf("t6_wait_%0d", i), 32'(ctrl), 32'(V_MSTALL));
            next_cycle();
        end
        mem_ack = 1'b1;
        settle();
        check("t6_ack_branch", 32'(ctrl), 32'(V_BRANCH));
        next_cycle();
        idle_inputs();

        // Load-use held during a wait bubbles in the release cycle.
        mem_req = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
        settle();
        check("t6_lu_wait", 32'(ctrl), 32'(V_MSTALL));
        next_cycle();
        mem_ack = 1'b1;
        settle();
        check("t6_lu_ack", 32'(ctrl), 32'(V_LDUSE));
        next_cycle();
        idle_inputs();

        // Asynchronous reset in the middle of a wait.
        mem_req = 1'b1;
        settle();
        next_cycle();
        check("t6_in_wait", 32'(ctrl), 32'(V_MSTALL));
        resetn = 1'b0;
        #1;
        check("t6_async_ctrl", 32'(ctrl), 32'(V_ZERO));
        check("t6_async_state", 32'(state_dbg), 32'(S_RUN));
        check("t6_async_stall", 32'(stall_cnt), 32'd0);
        next_cycle();
        idle_inputs();
        resetn = 1'b1;
        settle();
        check("t6_release", 32'(ctrl), 32'(V_NORMAL));
        next_cycle();
        check("t6_release_state", 32'(state_dbg), 32'(S_RUN));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
